pc_stack_unit: RTL and testbench



---
 rtl/pc_stack_pkg.sv | 18 +
 rtl/hw_return_stack.sv | 57 +++++
 rtl/pc_stack_unit.sv | 112 +++++++++++
 tb/tb_pc_stack_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Shared types for the program counter / return stack unit.
package pc_stack_pkg;

  // OP_INC is zero so an idle decoder yields plain increment.
  typedef enum logic [2:0] {
    OP_INC  = 3'd0,
    OP_SKIP = 3'd1,
    OP_GOTO = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

  // Stack pointer width for a given number of entries.
  function automatic int unsigned ptr_w(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/hw_return_stack.sv
// Circular hardware return stack: push overwrites the oldest entry when full,
// pop from empty still reads the slot the pointer selects.
module hw_return_stack
  import pc_stack_pkg::*;
#(
  parameter int unsigned PC_W        = 11,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              wdata,
  output logic [PC_W-1:0]              rdata,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         overflow_c,
  output logic                         underflow_c
);

  localparam int unsigned SP_W    = ptr_w(STACK_DEPTH);
  localparam int unsigned DEPTH_W = SP_W + 1;

  logic [PC_W-1:0]    mem [STACK_DEPTH];
  logic [SP_W-1:0]    sp_q;
  logic [DEPTH_W-1:0] depth_q;
  logic [SP_W-1:0]    sp_prev_c;
  logic               full_c;
  logic               empty_c;

  assign sp_prev_c   = sp_q - SP_W'(1);
  assign full_c      = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty_c     = (depth_q == '0);
  assign rdata       = mem[sp_prev_c];
  assign depth       = depth_q;
  assign overflow_c  = push & full_c;
  assign underflow_c = pop & empty_c;

  // Pointer and occupancy; depth saturates at both ends while sp keeps wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + SP_W'(1);
      if (!full_c) depth_q <= depth_q + DEPTH_W'(1);
    end else if (pop) begin
      sp_q <= sp_prev_c;
      if (!empty_c) depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  // Storage is deliberately not cleared on reset; a push in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[sp_q] <= wdata;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with skip/goto/call/return sequencing, ROM address output
// and a one-cycle flush pulse after every taken non-sequential op.
module pc_stack_unit
  import pc_stack_pkg::*;
#(
  parameter int unsigned      PC_W         = 11,
  parameter int unsigned      STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0]  RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   pc_op,
  input  logic [PC_W-1:0]              target,
  output logic [PC_W-1:0]              counter,
  output logic                         flush,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned DEPTH_W = ptr_w(STACK_DEPTH) + 1;

  logic [PC_W-1:0]    pc_q;
  logic               flush_q;
  logic               ovf_q;
  logic               unf_q;
  logic [PC_W-1:0]    pc_next_c;
  logic               flush_next_c;
  logic               push_c;
  logic               pop_c;
  logic [PC_W-1:0]    ret_addr_c;
  logic [PC_W-1:0]    stack_rdata;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_ovf_c;
  logic               stack_unf_c;

  assign ret_addr_c = pc_q + PC_W'(1);

  // Next-PC mux; a stall holds everything and suppresses the flush.
  always_comb begin
    pc_next_c    = pc_q + PC_W'(1);
    flush_next_c = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    if (!en) begin
      pc_next_c = pc_q;
    end else begin
      case (pc_op)
        OP_SKIP: begin
          pc_next_c    = pc_q + PC_W'(2);
          flush_next_c = 1'b1;
        end
        OP_GOTO: begin
          pc_next_c    = target;
          flush_next_c = 1'b1;
        end
        OP_CALL: begin
          pc_next_c    = target;
          flush_next_c = 1'b1;
          push_c       = 1'b1;
        end
        OP_RET: begin
          pc_next_c    = stack_rdata;
          flush_next_c = 1'b1;
          pop_c        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_next_c;
      flush_q <= flush_next_c;
      ovf_q   <= ovf_q | stack_ovf_c;
      unf_q   <= unf_q | stack_unf_c;
    end
  end

  hw_return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push        (push_c),
    .pop         (pop_c),
    .wdata       (ret_addr_c),
    .rdata       (stack_rdata),
    .depth       (stack_depth),
    .overflow_c  (stack_ovf_c),
    .underflow_c (stack_unf_c)
  );

  assign counter     = pc_q;
  assign flush       = flush_q;
  assign depth       = stack_depth;
  assign stack_full  = (stack_depth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (stack_depth == '0);
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit with default parameters.
module tb_pc_stack_unit;
  import pc_stack_pkg::*;

  localparam int unsigned PC_W        = 11;
  localparam int unsigned STACK_DEPTH = 8;

  logic            clk;
  logic            reset;
  logic            en;
  logic [2:0]      pc_op;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] counter;
  logic            flush;
  logic [3:0]      depth;
  logic            stack_full;
  logic            stack_empty;
  logic            overflow;
  logic            underflow;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack_unit #(
    .PC_W         (PC_W),
    .STACK_DEPTH  (STACK_DEPTH),
    .RESET_VECTOR ('0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .pc_op       (pc_op),
    .target      (target),
    .counter     (counter),
    .flush       (flush),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [PC_W-1:0] tgt);
    pc_op  = op;
    target = tgt;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    pc_op  = OP_INC;
    target = '0;
    tick();
    tick();
    check_eq("rst_counter", counter, 0);
    check_eq("rst_depth", depth, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_unf", underflow, 0);
    check_eq("rst_empty", stack_empty, 1);
    check_eq("rst_full", stack_full, 0);
    reset = 1'b0;

    // Five increments, no flush.
    for (int i = 1; i <= 5; i++) begin
      do_op(OP_INC, '0);
      check_eq("inc_flush", flush, 0);
    end
    check_eq("inc_counter", counter, 5);

    // Wrap behaviour at the top of the address space.
    do_op(OP_GOTO, 11'd2046);
    check_eq("goto_counter", counter, 2046);
    check_eq("goto_flush", flush, 1);
    do_op(OP_INC, '0);
    check_eq("inc_top", counter, 2047);
    check_eq("inc_top_flush", flush, 0);
    do_op(OP_SKIP, '0);
    check_eq("skip_wrap", counter, 1);
    check_eq("skip_flush", flush, 1);
    do_op(OP_INC, '0);
    check_eq("skip_flush_once", flush, 0);
    check_eq("inc_after_skip", counter, 2);
    do_op(OP_GOTO, 11'h7FF);
    check_eq("goto_top", counter, 2047);
    do_op(OP_CALL, 11'd10);
    check_eq("call_top_counter", counter, 10);
    do_op(OP_RET, '0);
    check_eq("ret_addr_wrap", counter, 0);
    check_eq("ret_top_depth", depth, 0);

    // Simple call / return.
    do_op(OP_GOTO, 11'd10);
    do_op(OP_CALL, 11'd100);
    check_eq("call_counter", counter, 100);
    check_eq("call_depth", depth, 1);
    check_eq("call_flush", flush, 1);
    check_eq("call_empty", stack_empty, 0);
    do_op(OP_INC, '0);
    check_eq("call_inc", counter, 101);
    do_op(OP_RET, '0);
    check_eq("ret_counter", counter, 11);
    check_eq("ret_depth", depth, 0);
    check_eq("ret_empty", stack_empty, 1);
    check_eq("ret_flush", flush, 1);

    // Nine nested calls from addresses 0..8 overflow the eight-entry stack.
    for (int i = 0; i < 9; i++) begin
      do_op(OP_GOTO, 11'(i));
      do_op(OP_CALL, 11'(20 + i));
      check_eq("nest_counter", counter, 20 + i);
      if (i == 7) begin
        check_eq("nest8_full", stack_full, 1);
        check_eq("nest8_ovf", overflow, 0);
      end
    end
    check_eq("ovf_depth", depth, 8);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_full", stack_full, 1);
    check_eq("ovf_unf", underflow, 0);

    // Returns come back 9,8,...,2; the overwritten oldest slot now holds 9.
    for (int i = 0; i < 8; i++) begin
      do_op(OP_RET, '0);
      check_eq("pop_counter", counter, (i == 0) ? 9 : 9 - i);
      check_eq("pop_depth", depth, 7 - i);
    end
    check_eq("pop_unf_clear", underflow, 0);
    do_op(OP_RET, '0);
    check_eq("unf_counter", counter, 9);
    check_eq("unf_flag", underflow, 1);
    check_eq("unf_depth", depth, 0);
    check_eq("unf_ovf_sticky", overflow, 1);

    // Undefined encoding acts as increment.
    do_op(3'd7, 11'd300);
    check_eq("undef_counter", counter, 10);
    check_eq("undef_flush", flush, 0);

    // Stall with a call pending.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(OP_CALL, 11'd50);
      check_eq("stall_counter", counter, 10);
      check_eq("stall_depth", depth, 0);
      check_eq("stall_flush", flush, 0);
      check_eq("stall_unf", underflow, 1);
    end
    en = 1'b1;
    do_op(OP_CALL, 11'd50);
    check_eq("unstall_counter", counter, 50);
    check_eq("unstall_depth", depth, 1);
    check_eq("unstall_flush", flush, 1);

    do_op(OP_CALL, 11'd60);
    do_op(OP_CALL, 11'd70);
    check_eq("d3_depth", depth, 3);
    check_eq("d3_counter", counter, 70);

    // Reset beats a simultaneous call; the call is discarded.
    reset = 1'b1;
    do_op(OP_CALL, 11'd77);
    check_eq("rstcall_counter", counter, 0);
    check_eq("rstcall_depth", depth, 0);
    check_eq("rstcall_flush", flush, 0);
    check_eq("rstcall_ovf", overflow, 0);
    check_eq("rstcall_unf", underflow, 0);
    reset = 1'b0;
    // Pointer is back at 0, so the return reads slot 7, which still holds 8.
    do_op(OP_RET, '0);
    check_eq("post_rst_unf", underflow, 1);
    check_eq("post_rst_depth", depth, 0);
    check_eq("post_rst_counter", counter, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
